// File: rtl/oam_dma.sv
// ---------------------------------------------------------------------------
// oam_dma
//
// Sprite OAM DMA engine acting as a bus initiator on the CPU bus. A CPU write
// to PAGE_REG latches a source page and stalls the CPU. Once the CPU reaches
// a read cycle, the engine takes the bus. After one or two dummy reads that
// align it to the CPU cycle parity, it copies LEN bytes from {page,idx} to
// OAM_PORT as alternating read/write cycles. It then releases the bus and
// pulses done. The surrounding top level muxes addr/rw/data on bus_own.
//
// Ports
//   clk        in   1   CPU-phase clock, rising edge
//   sys_reset  in   1   synchronous, active-high reset
//   cpu_addr   in   16  CPU address bus
//   cpu_wdata  in   8   CPU write data
//   cpu_rw     in   1   CPU rw, 1=read 0=write
//   cpu_halt   out  1   1 = pull sys_rdy low (stall CPU)
//   bus_own    out  1   1 = DMA drives sys_addr/sys_rw/sys_data
//   dma_addr   out  16  DMA address, valid while bus_own
//   dma_rw     out  1   DMA rw, 1=read 0=write
//   dma_wdata  out  8   DMA write data, valid while bus_own & ~dma_rw
//   bus_rdata  in   8   read data from the addressed responder
//   bus_rdy    in   1   responder ready, 0 inserts a wait state
//   busy       out  1   high from the start-write edge until done
//   done       out  1   one-cycle pulse after the final OAM write
// ---------------------------------------------------------------------------
module oam_dma #(
    parameter logic [15:0] PAGE_REG = 16'h4014,
    parameter logic [15:0] OAM_PORT = 16'h2004,
    parameter int          LEN      = 256
) (
    input  logic        clk,
    input  logic        sys_reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_rw,
    output logic        cpu_halt,
    output logic        bus_own,
    output logic [15:0] dma_addr,
    output logic        dma_rw,
    output logic [7:0]  dma_wdata,
    input  logic [7:0]  bus_rdata,
    input  logic        bus_rdy,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_ALIGN,
        S_ALIGN2,
        S_READ,
        S_WRITE
    } state_t;

    state_t      state_q,     state_d;
    logic [7:0]  page_q,      page_d;
    logic [7:0]  idx_q,       idx_d;
    logic        cyc_odd_q,   cyc_odd_d;
    logic        cpu_halt_q,  cpu_halt_d;
    logic        bus_own_q,   bus_own_d;
    logic        busy_q,      busy_d;
    logic        done_q,      done_d;
    logic        dma_rw_q,    dma_rw_d;
    logic [15:0] dma_addr_q,  dma_addr_d;
    logic [7:0]  dma_wdata_q, dma_wdata_d;

    always_comb begin
        state_d     = state_q;
        page_d      = page_q;
        idx_d       = idx_q;
        dma_wdata_d = dma_wdata_q;
        done_d      = 1'b0;
        // Parity reference for the alignment decision; runs regardless of state.
        cyc_odd_d   = ~cyc_odd_q;

        case (state_q)
            S_IDLE: begin
                // Only an idle engine accepts a start; PAGE_REG writes while
                // busy never re-latch the page.
                if (cpu_addr == PAGE_REG && !cpu_rw) begin
                    page_d  = cpu_wdata;
                    idx_d   = 8'h00;
                    state_d = S_HALT;
                end
            end
            S_HALT: begin
                // The CPU ignores RDY during write cycles, so the bus can only
                // be taken once it is sitting in a read cycle.
                if (cpu_rw) begin
                    state_d = S_ALIGN;
                end
            end
            S_ALIGN: begin
                state_d = cyc_odd_q ? S_ALIGN2 : S_READ;
            end
            S_ALIGN2: begin
                state_d = S_READ;
            end
            S_READ: begin
                if (bus_rdy) begin
                    dma_wdata_d = bus_rdata;
                    state_d     = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus_rdy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // 8-bit wrap: page $FF stays within $FF00-$FFFF.
                        idx_d   = idx_q + 8'd1;
                        state_d = S_READ;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register
        // cycle-aligned with the state they describe.
        cpu_halt_d = (state_d != S_IDLE);
        busy_d     = (state_d != S_IDLE);
        bus_own_d  = (state_d != S_IDLE) && (state_d != S_HALT);
        dma_rw_d   = (state_d != S_WRITE);
        case (state_d)
            S_ALIGN, S_ALIGN2: dma_addr_d = PAGE_REG;  // dummy read, data discarded
            S_READ:            dma_addr_d = {page_d, idx_d};
            S_WRITE:           dma_addr_d = OAM_PORT;
            default:           dma_addr_d = 16'h0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (sys_reset) begin
            state_q     <= S_IDLE;
            page_q      <= 8'h00;
            idx_q       <= 8'h00;
            cyc_odd_q   <= 1'b0;
            cpu_halt_q  <= 1'b0;
            bus_own_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            dma_rw_q    <= 1'b1;
            dma_addr_q  <= 16'h0000;
            dma_wdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            page_q      <= page_d;
            idx_q       <= idx_d;
            cyc_odd_q   <= cyc_odd_d;
            cpu_halt_q  <= cpu_halt_d;
            bus_own_q   <= bus_own_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            dma_rw_q    <= dma_rw_d;
            dma_addr_q  <= dma_addr_d;
            dma_wdata_q <= dma_wdata_d;
        end
    end

    assign cpu_halt  = cpu_halt_q;
    assign bus_own   = bus_own_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dma_rw    = dma_rw_q;
    assign dma_addr  = dma_addr_q;
    assign dma_wdata = dma_wdata_q;

endmodule

// File: tb/tb_oam_dma.sv
// ---------------------------------------------------------------------------
// tb_oam_dma
//
// Bench for oam_dma. The reference keeps an ordered queue of the bus
// operations a transfer must perform: alignment dummy reads, then read/write
// pairs. The head of the queue is what the bus must show. The head retires
// when the responder is ready, or immediately for a dummy read. The bench
// also acts as the CPU and as the RAM responder.
// ---------------------------------------------------------------------------
module tb_oam_dma;

    localparam logic [15:0] PAGE_REG = 16'h4014;
    localparam logic [15:0] OAM_PORT = 16'h2004;
    localparam int          LEN      = 256;

    logic        clk = 1'b0;
    logic        sys_reset;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rw;
    logic        cpu_halt;
    logic        bus_own;
    logic [15:0] dma_addr;
    logic        dma_rw;
    logic [7:0]  dma_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_rdy;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    oam_dma #(.PAGE_REG(PAGE_REG), .OAM_PORT(OAM_PORT), .LEN(LEN)) dut (
        .clk       (clk),
        .sys_reset (sys_reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rw    (cpu_rw),
        .cpu_halt  (cpu_halt),
        .bus_own   (bus_own),
        .dma_addr  (dma_addr),
        .dma_rw    (dma_rw),
        .dma_wdata (dma_wdata),
        .bus_rdata (bus_rdata),
        .bus_rdy   (bus_rdy),
        .busy      (busy),
        .done      (done)
    );

    // RAM responder
    logic [7:0] ram [0:65535];
    assign bus_rdata = ram[dma_addr];

    // Reference model
    typedef struct {
        logic [15:0] addr;
        logic        rw;
        logic [7:0]  wdata;
        bit          dummy;
        int          idx;
    } op_t;

    op_t        q[$];
    bit         m_busy    = 1'b0;
    bit         m_wait_rd = 1'b0;
    bit         m_done    = 1'b0;
    bit         m_par     = 1'b0;
    logic [7:0] m_page    = 8'h00;

    int n_checks = 0;
    int n_fail   = 0;
    int own_cnt  = 0;
    int done_cnt = 0;
    int obs_cnt  = 0;
    logic [7:0] obs [0:255];

    int rdy_mode = 0;  // 0: always ready, 1: random, 2: directed stall at idx $10
    int stall_rd = 0;
    int stall_wr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic build_ops(input bit par);
        op_t o;
        q.delete();
        for (int d = 0; d < 1 + int'(par); d++) begin
            o.addr = PAGE_REG; o.rw = 1'b1; o.wdata = 8'h00; o.dummy = 1'b1; o.idx = -1;
            q.push_back(o);
        end
        for (int i = 0; i < LEN; i++) begin
            o.addr = {m_page, 8'(i)}; o.rw = 1'b1; o.wdata = 8'h00; o.dummy = 1'b0; o.idx = i;
            q.push_back(o);
            o.addr = OAM_PORT; o.rw = 1'b0; o.wdata = ram[{m_page, 8'(i)}];
            q.push_back(o);
        end
    endtask

    // Model advance at each rising edge, from the inputs the DUT samples.
    initial forever begin
        bit pop;
        @(posedge clk);
        if (sys_reset) begin
            m_busy = 1'b0; m_wait_rd = 1'b0; m_done = 1'b0; m_par = 1'b0;
            q.delete();
        end else begin
            pop    = m_busy && !m_wait_rd && q.size() > 0 && (q[0].dummy || bus_rdy === 1'b1);
            m_par  = !m_par;
            m_done = 1'b0;
            if (!m_busy) begin
                if (cpu_addr == PAGE_REG && cpu_rw == 1'b0) begin
                    m_busy = 1'b1; m_wait_rd = 1'b1; m_page = cpu_wdata;
                end
            end else if (m_wait_rd) begin
                if (cpu_rw) begin
                    m_wait_rd = 1'b0;
                    build_ops(m_par);
                end
            end else if (pop) begin
                void'(q.pop_front());
                if (q.size() == 0) begin
                    m_busy = 1'b0; m_done = 1'b1;
                end
            end
        end
    end

    // Responder ready driver
    initial begin
        bus_rdy = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0: bus_rdy = 1'b1;
                1: bus_rdy = ($urandom_range(0, 3) != 0);
                default: begin
                    bus_rdy = 1'b1;
                    if (m_busy && !m_wait_rd && q.size() > 0 && !q[0].dummy && q[0].idx == 16) begin
                        if (q[0].rw && stall_rd > 0) begin
                            bus_rdy = 1'b0; stall_rd--;
                        end else if (!q[0].rw && stall_wr > 0) begin
                            bus_rdy = 1'b0; stall_wr--;
                        end
                    end
                end
            endcase
        end
    end

    // Per-cycle compare
    initial forever begin
        @(negedge clk);
        check("cpu_halt", cpu_halt, m_busy);
        check("busy", busy, m_busy);
        check("bus_own", bus_own, m_busy && !m_wait_rd);
        check("done", done, m_done);
        if (m_busy && !m_wait_rd && q.size() > 0) begin
            check("dma_addr", dma_addr, q[0].addr);
            check("dma_rw", dma_rw, q[0].rw);
            if (!q[0].rw) check("dma_wdata", dma_wdata, q[0].wdata);
        end
        if (bus_own === 1'b1) own_cnt++;
        if (done === 1'b1) done_cnt++;
        if (bus_own === 1'b1 && dma_rw === 1'b0 && bus_rdy === 1'b1) begin
            if (obs_cnt < 256) obs[obs_cnt] = dma_wdata;
            obs_cnt++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic clear_counts();
        own_cnt = 0; done_cnt = 0; obs_cnt = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_cpu_halt"}, cpu_halt, 0);
        check({tag, "_bus_own"}, bus_own, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_dma_rw"}, dma_rw, 1);
        check({tag, "_dma_addr"}, dma_addr, 0);
        check({tag, "_dma_wdata"}, dma_wdata, 0);
    endtask

    // Issue a PAGE_REG write, keep the CPU in write cycles for 'extra' more
    // cycles, then move it to reads. want >= 0 picks the parity of the first
    // ALIGN cycle.
    task automatic start(input logic [7:0] pg, input int want, input int extra);
        @(posedge clk); #1;
        if (want >= 0) begin
            while (m_par != (want[0] ^ extra[0])) begin
                @(posedge clk); #1;
            end
        end
        cpu_addr = PAGE_REG; cpu_rw = 1'b0; cpu_wdata = pg;
        @(posedge clk); #1;
        for (int k = 0; k < extra; k++) begin
            cpu_addr = 16'h0100 | 16'($urandom_range(0, 255)); cpu_rw = 1'b0;
            check("halt_wr_cpu_halt", cpu_halt, 1);
            check("halt_wr_bus_own", bus_own, 0);
            @(posedge clk); #1;
        end
        cpu_rw = 1'b1; cpu_addr = 16'h8000 | 16'($urandom_range(0, 255));
        if (extra > 0) begin
            check("halt_rd_bus_own", bus_own, 0);
            @(posedge clk); #1;
            check("align_bus_own", bus_own, 1);
            check("align_addr", dma_addr, PAGE_REG);
            check("align_rw", dma_rw, 1);
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(posedge clk); #1; n++;
        end
        check("done_seen", done === 1'b1, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_stream_a5(input string tag);
        check({tag, "_bytes"}, obs_cnt, 256);
        for (int i = 0; i < 256; i++) check({tag, "_byte"}, obs[i], 8'(i) ^ 8'hA5);
    endtask

    initial begin
        int n;
        sys_reset = 1'b1; cpu_addr = 16'h0000; cpu_wdata = 8'h00; cpu_rw = 1'b1;
        for (int a = 0; a < 65536; a++) begin
            ram[a] = (a[15:8] == 8'h02) ? (8'(a) ^ 8'hA5) : 8'($urandom);
        end
        repeat (3) @(posedge clk);
        #2;
        check_idle_outputs("reset");
        sys_reset = 1'b0;

        // Page $02, even alignment parity, always ready.
        clear_counts();
        start(8'h02, 0, 0);
        wait_done(2000);
        check("even_own_cycles", own_cnt, 513);
        check("even_done_pulses", done_cnt, 1);
        check_stream_a5("even");

        // Odd alignment parity: one extra dummy read.
        clear_counts();
        start(8'h02, 1, 0);
        wait_done(2000);
        check("odd_own_cycles", own_cnt, 514);
        check_stream_a5("odd");

        // CPU stays in write cycles two more cycles after the start.
        clear_counts();
        start(8'h02, -1, 2);
        wait_done(2000);
        check("halt_done_pulses", done_cnt, 1);

        // Wait states at idx $10: 3 during the read, 2 during the write.
        clear_counts();
        stall_rd = 3; stall_wr = 2; rdy_mode = 2;
        start(8'h02, 0, 0);
        wait_done(2000);
        check("stall_own_cycles", own_cnt, 518);
        check("stall_byte10", obs[16], 8'hB5);
        check("stall_rd_used", stall_rd, 0);
        check("stall_wr_used", stall_wr, 0);
        rdy_mode = 0;

        // Reset in the write of idx 100, then a clean transfer from $0300.
        start(8'h02, -1, 0);
        n = 0;
        while (!(m_busy && !m_wait_rd && q.size() > 0 && !q[0].dummy && !q[0].rw && q[0].idx == 100)
               && n < 2000) begin
            @(posedge clk); #1; n++;
        end
        check("reach_idx100_addr", dma_addr, OAM_PORT);
        check("reach_idx100_rw", dma_rw, 0);
        sys_reset = 1'b1;
        @(posedge clk); #1;
        sys_reset = 1'b0;
        check_idle_outputs("midreset");
        clear_counts();
        start(8'h03, -1, 0);
        wait_done(2000);
        check("p3_bytes", obs_cnt, 256);
        check("p3_first", obs[0], ram[16'h0300]);
        check("p3_last", obs[255], ram[16'h03FF]);

        // PAGE_REG write mid-transfer is ignored; $4015 write and $4014 read while idle too.
        clear_counts();
        rdy_mode = 1;
        start(8'h02, -1, 0);
        repeat (100) begin @(posedge clk); #1; end
        cpu_addr = PAGE_REG; cpu_rw = 1'b0; cpu_wdata = 8'h07;
        @(posedge clk); #1;
        cpu_addr = 16'h8000; cpu_rw = 1'b1;
        wait_done(4000);
        check_stream_a5("ignored");
        cpu_addr = 16'h4015; cpu_rw = 1'b0; cpu_wdata = 8'h07;
        @(posedge clk); #1;
        cpu_addr = PAGE_REG; cpu_rw = 1'b1;
        @(posedge clk); #1;
        cpu_addr = 16'h8000;
        @(posedge clk); #1;
        check("ignored_busy", busy, 0);
        check("ignored_halt", cpu_halt, 0);

        // A PAGE_REG write held through the done cycle starts the next transfer.
        start(8'h11, -1, 0);
        repeat (20) begin @(posedge clk); #1; end
        cpu_addr = PAGE_REG; cpu_rw = 1'b0; cpu_wdata = 8'h22;
        wait_done(4000);
        check("b2b_busy", busy, 1);
        check("b2b_halt", cpu_halt, 1);
        check("b2b_bus_own", bus_own, 0);
        cpu_addr = 16'h8000; cpu_rw = 1'b1;
        wait_done(4000);

        // Random pages, halt lengths and wait states, including page $FF.
        for (int r = 0; r < 6; r++) begin
            start((r == 0) ? 8'hFF : 8'($urandom), -1, $urandom_range(0, 3));
            wait_done(4000);
        end
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #2;
        check("final_busy", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
